// File: rtl/cppf_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cppf_ctrl_pkg
//  Description : Shared types and widths for the CPPF link bring-up and
//                recovery sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cppf_ctrl_pkg;

  localparam int CRC_CNT_W = 16;
  localparam int REC_CNT_W = 8;
  localparam int BAD_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_RESET_RX  = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_BUF_RESET = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_MONITOR   = 3'd5
  } cppf_ctrl_state_t;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cppf_link_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cppf_link_ctrl_if
//  Description : Link-block control and status bundle of the CPPF sequencer.
//                master = sequencer side, slave = link block / core side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cppf_link_ctrl_if #(
  parameter int NLINK = 7
);
  import cppf_ctrl_pkg::*;

  logic                                ttc_bc0;
  logic [NLINK-1:0]                    fiber_enable;
  logic [NLINK-1:0]                    rxresetdone;
  logic [NLINK-1:0]                    rx_valid;
  logic [NLINK-1:0]                    crc_match;
  logic                                force_reset;
  logic                                cnt_clear;
  logic                                soft_reset_rx;
  logic                                rxbufreset;
  logic [NLINK-1:0]                    link_good;
  logic                                busy;
  logic [NLINK-1:0][CRC_CNT_W-1:0]     crc_err_cnt;
  logic [REC_CNT_W-1:0]                recovery_cnt;

  modport master (
    input  ttc_bc0, fiber_enable, rxresetdone, rx_valid, crc_match,
           force_reset, cnt_clear,
    output soft_reset_rx, rxbufreset, link_good, busy, crc_err_cnt,
           recovery_cnt
  );

  modport slave (
    output ttc_bc0, fiber_enable, rxresetdone, rx_valid, crc_match,
           force_reset, cnt_clear,
    input  soft_reset_rx, rxbufreset, link_good, busy, crc_err_cnt,
           recovery_cnt
  );

endinterface
`default_nettype wire

// File: rtl/cppf_link_ctrl_err_mon.sv
`default_nettype none
// ============================================================================
//  Module      : cppf_link_err_mon
//  Description : Per-link health monitor: consecutive-bad BC0 counter,
//                saturating CRC error counter and registered link_good flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cppf_link_err_mon
  import cppf_ctrl_pkg::*;
#(
  parameter int ERR_THRESH = 8
) (
  input  wire logic                 clk_40,
  input  wire logic                 reset,
  input  wire logic                 enable_i,     // fiber_enable for this link
  input  wire logic                 rx_valid_i,
  input  wire logic                 crc_match_i,
  input  wire logic                 monitor_i,    // sequencer is in MONITOR
  input  wire logic                 sample_i,     // MONITOR and BC0 this cycle
  input  wire logic                 clr_bad_i,    // entering RESET_RX
  input  wire logic                 cnt_clear_i,
  output logic                      trip_o,       // counter reaches threshold
  output logic                      link_good_o,
  output logic [CRC_CNT_W-1:0]      crc_err_cnt_o
);

  logic [BAD_CNT_W-1:0] bad_q, bad_d, bad_nxt;
  logic [CRC_CNT_W-1:0] crc_q;
  logic                 link_good_q;
  logic                 bad;
  logic                 crc_inc;

  assign bad     = ~rx_valid_i | ~crc_match_i;
  assign crc_inc = monitor_i & enable_i & rx_valid_i & ~crc_match_i;

  // Next consecutive-bad count; trip is taken before the entry clear so the
  // clear (which depends on trip through the FSM) cannot loop back.
  always_comb begin
    bad_nxt = bad_q;
    if (!enable_i) begin
      bad_nxt = '0;
    end else if (sample_i) begin
      if (!bad)                bad_nxt = '0;
      else if (bad_q != '1)    bad_nxt = bad_q + BAD_CNT_W'(1);
    end
    trip_o = sample_i & (bad_nxt >= BAD_CNT_W'(ERR_THRESH));
    bad_d  = clr_bad_i ? '0 : bad_nxt;
  end

  // Counter and flag registers; cnt_clear beats a same-cycle increment.
  always_ff @(posedge clk_40) begin
    if (reset) begin
      bad_q       <= '0;
      crc_q       <= '0;
      link_good_q <= 1'b0;
    end else begin
      bad_q       <= bad_d;
      link_good_q <= monitor_i & enable_i & (bad_q == '0) & rx_valid_i;
      if (cnt_clear_i)                 crc_q <= '0;
      else if (crc_inc && crc_q != '1) crc_q <= crc_q + CRC_CNT_W'(1);
    end
  end

  assign link_good_o   = link_good_q;
  assign crc_err_cnt_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/cppf_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cppf_link_ctrl
//  Description : Bring-up and recovery sequencer for the CPPF receive links.
//                Resets the RX path, waits for reset done, settles for a few
//                orbits, then monitors link health and re-runs recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module cppf_link_ctrl
  import cppf_ctrl_pkg::*;
#(
  parameter int NLINK         = 7,
  parameter int RST_CYCLES    = 16,
  parameter int BUF_CYCLES    = 4,
  parameter int DONE_TIMEOUT  = 4000,
  parameter int SETTLE_ORBITS = 4,
  parameter int ERR_THRESH    = 8
) (
  input  wire logic         clk_40,
  input  wire logic         reset,
  cppf_link_ctrl_if.master  lnk
);

  // One counter serves every phase: hold cycles, timeout, settle BC0 count.
  localparam int CYC_W = $clog2(imax(imax(RST_CYCLES, BUF_CYCLES),
                                     imax(DONE_TIMEOUT, SETTLE_ORBITS)) + 1);

  cppf_ctrl_state_t      state_q, state_d;
  logic [CYC_W-1:0]      cyc_q, cyc_d;
  logic                  soft_q, buf_q, busy_q;
  logic [REC_CNT_W-1:0]  rec_q;
  logic                  all_done;
  logic                  enter_rst;
  logic                  in_monitor;
  logic                  sample;
  logic [NLINK-1:0]      trip;
  logic [NLINK-1:0]      good;
  logic [NLINK-1:0][CRC_CNT_W-1:0] crc_cnt;

  // Disabled links count as done, so an all-disabled mask passes at once.
  assign all_done   = &(lnk.rxresetdone | ~lnk.fiber_enable);
  assign in_monitor = (state_q == ST_MONITOR);
  assign sample     = in_monitor & lnk.ttc_bc0;

  // Next-state and phase counter; force_reset overrides every transition.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CYC_W'(1);
    case (state_q)
      ST_INIT:      state_d = ST_RESET_RX;
      ST_RESET_RX:  if (cyc_q == CYC_W'(RST_CYCLES - 1)) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (all_done)                                 state_d = ST_BUF_RESET;
        else if (cyc_q == CYC_W'(DONE_TIMEOUT - 1))   state_d = ST_RESET_RX;
      end
      ST_BUF_RESET: if (cyc_q == CYC_W'(BUF_CYCLES - 1)) state_d = ST_SETTLE;
      ST_SETTLE: begin
        cyc_d = cyc_q;
        if (lnk.ttc_bc0) begin
          if (cyc_q == CYC_W'(SETTLE_ORBITS - 1)) state_d = ST_MONITOR;
          else                                    cyc_d   = cyc_q + CYC_W'(1);
        end
      end
      ST_MONITOR: begin
        cyc_d = cyc_q;
        if (|trip) state_d = ST_RESET_RX;
      end
      default:      state_d = ST_INIT;
    endcase
    if (lnk.force_reset) state_d = ST_RESET_RX;
    if (state_d != state_q || lnk.force_reset) cyc_d = '0;
    enter_rst = (state_d == ST_RESET_RX) &&
                ((state_q != ST_RESET_RX) || lnk.force_reset);
  end

  // State register and registered link-block controls and status.
  always_ff @(posedge clk_40) begin
    if (reset) begin
      state_q <= ST_INIT;
      cyc_q   <= '0;
      soft_q  <= 1'b0;
      buf_q   <= 1'b0;
      busy_q  <= 1'b1;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      soft_q  <= (state_q == ST_RESET_RX);
      buf_q   <= (state_q == ST_BUF_RESET);
      busy_q  <= (state_d != ST_MONITOR);
      if (lnk.cnt_clear)                rec_q <= '0;
      else if (enter_rst && rec_q != '1) rec_q <= rec_q + REC_CNT_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < NLINK; i++) begin : g_link
      cppf_link_err_mon #(
        .ERR_THRESH (ERR_THRESH)
      ) u_mon (
        .clk_40        (clk_40),
        .reset         (reset),
        .enable_i      (lnk.fiber_enable[i]),
        .rx_valid_i    (lnk.rx_valid[i]),
        .crc_match_i   (lnk.crc_match[i]),
        .monitor_i     (in_monitor),
        .sample_i      (sample),
        .clr_bad_i     (enter_rst),
        .cnt_clear_i   (lnk.cnt_clear),
        .trip_o        (trip[i]),
        .link_good_o   (good[i]),
        .crc_err_cnt_o (crc_cnt[i])
      );
    end
  endgenerate

  assign lnk.soft_reset_rx = soft_q;
  assign lnk.rxbufreset    = buf_q;
  assign lnk.busy          = busy_q;
  assign lnk.recovery_cnt  = rec_q;
  assign lnk.link_good     = good;
  assign lnk.crc_err_cnt   = crc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cppf_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cppf_link_ctrl
//  Description : Directed self-checking bench for cppf_link_ctrl. A pulse
//                monitor pops expected soft_reset_rx / rxbufreset widths
//                from queues filled by the stimulus sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cppf_link_ctrl;
  import cppf_ctrl_pkg::*;

  localparam int NL       = 7;
  localparam int BC0_GAP  = 16;
  localparam int DONE_DLY = 100;

  logic clk_40 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_40 = ~clk_40;

  cppf_link_ctrl_if #(.NLINK(NL)) lnk ();

  cppf_link_ctrl #(
    .NLINK(NL), .RST_CYCLES(16), .BUF_CYCLES(4), .DONE_TIMEOUT(4000),
    .SETTLE_ORBITS(4), .ERR_THRESH(8)
  ) u_dut (
    .clk_40 (clk_40),
    .reset  (reset),
    .lnk    (lnk)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sb_soft[$];
  int sb_buf[$];
  logic [NL-1:0] stuck = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_40);
  endtask

  task automatic orbit(input logic [NL-1:0] crc_bad);
    tick(BC0_GAP - 1);
    lnk.ttc_bc0   = 1'b1;
    lnk.crc_match = ~crc_bad;
    tick(1);
    lnk.ttc_bc0   = 1'b0;
    lnk.crc_match = '1;
  endtask

  task automatic wait_buf_done(input string tag);
    int k = 0;
    while (lnk.rxbufreset !== 1'b1 && k < 6000) begin tick(1); k++; end
    while (lnk.rxbufreset === 1'b1 && k < 6000) begin tick(1); k++; end
    check({tag, " buffer reset within budget"}, 32'(k < 6000), 1);
  endtask

  task automatic settle(input string tag, input logic [NL-1:0] last_bad);
    orbit('0); orbit('0); orbit('0);
    check({tag, " busy after 3 BC0"}, lnk.busy, 1);
    orbit(last_bad);
    check({tag, " busy after 4th BC0"}, lnk.busy, 0);
  endtask

  // Transceiver model: reset done rises DONE_DLY cycles after soft reset ends.
  initial begin : xcvr
    int dcnt;
    dcnt = 0;
    lnk.rxresetdone = '0;
    forever begin
      @(negedge clk_40);
      if (lnk.soft_reset_rx === 1'b1) begin
        dcnt = 0;
        lnk.rxresetdone = '0;
      end else if (dcnt < DONE_DLY) begin
        dcnt++;
      end else begin
        lnk.rxresetdone = ~stuck;
      end
    end
  end

  // Pulse monitor: measure each control pulse and compare to the scoreboard.
  initial begin : pulse_mon
    int w_soft, w_buf;
    w_soft = 0;
    w_buf  = 0;
    forever begin
      @(negedge clk_40);
      if (lnk.soft_reset_rx === 1'b1) w_soft++;
      else if (w_soft > 0) begin
        if (sb_soft.size() == 0) check("soft_reset_rx unexpected pulse", w_soft, 0);
        else                     check("soft_reset_rx width", w_soft, sb_soft.pop_front());
        w_soft = 0;
      end
      if (lnk.rxbufreset === 1'b1) w_buf++;
      else if (w_buf > 0) begin
        if (sb_buf.size() == 0) check("rxbufreset unexpected pulse", w_buf, 0);
        else                    check("rxbufreset width", w_buf, sb_buf.pop_front());
        w_buf = 0;
      end
    end
  end

  initial begin : stim
    int k;
    lnk.ttc_bc0      = 1'b0;
    lnk.fiber_enable = '1;
    lnk.rx_valid     = '1;
    lnk.crc_match    = '1;
    lnk.force_reset  = 1'b0;
    lnk.cnt_clear    = 1'b0;
    reset = 1'b1;
    tick(3);

    check("reset soft_reset_rx", lnk.soft_reset_rx, 0);
    check("reset rxbufreset", lnk.rxbufreset, 0);
    check("reset link_good", lnk.link_good, 0);
    check("reset busy", lnk.busy, 1);
    check("reset recovery_cnt", lnk.recovery_cnt, 0);
    check("reset crc_err_cnt", 32'(lnk.crc_err_cnt === '0), 1);

    // Bring-up with all links enabled.
    sb_soft.push_back(16);
    sb_buf.push_back(4);
    reset = 1'b0;
    tick(1);
    check("INIT cycle soft_reset_rx", lnk.soft_reset_rx, 0);
    check("recovery_cnt on entry", lnk.recovery_cnt, 1);
    tick(1);
    check("soft_reset_rx rises", lnk.soft_reset_rx, 1);
    wait_buf_done("bring-up");
    settle("bring-up", 7'h40);
    tick(2);
    check("bring-up link_good", lnk.link_good, 7'h7F);
    check("bring-up recovery_cnt", lnk.recovery_cnt, 1);
    check("settle-edge BC0 not sampled", lnk.crc_err_cnt[6], 0);

    // Force from MONITOR, then reset in the middle of RESET_RX.
    sb_soft.push_back(4);
    lnk.force_reset = 1'b1; tick(1); lnk.force_reset = 1'b0;
    k = 0;
    while (lnk.soft_reset_rx !== 1'b1 && k < 50) begin tick(1); k++; end
    check("soft_reset_rx one cycle after entry", k, 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    check("reset drops soft_reset_rx", lnk.soft_reset_rx, 0);
    check("reset busy mid-sequence", lnk.busy, 1);
    check("reset clears recovery_cnt", lnk.recovery_cnt, 0);
    check("reset link_good mid-sequence", lnk.link_good, 0);

    // Link 3 never reports done: timeout and retry, then disable link 3.
    stuck = 7'h08;
    tick(2);
    sb_soft.push_back(16);
    sb_soft.push_back(16);
    reset = 1'b0;
    k = 0;
    while (lnk.recovery_cnt !== 8'd2 && k < 6000) begin tick(1); k++; end
    check("timeout retry recovery_cnt", lnk.recovery_cnt, 2);
    check("timeout retry latency", k, 4017);
    check("timeout no buffer reset", lnk.rxbufreset, 0);
    check("timeout busy", lnk.busy, 1);
    lnk.fiber_enable = 7'h77;
    sb_buf.push_back(4);
    wait_buf_done("retry");
    settle("retry", 7'h00);
    tick(2);
    check("link 3 disabled link_good", lnk.link_good, 7'h77);
    check("retry recovery_cnt", lnk.recovery_cnt, 2);

    // Link 5 CRC errors on 8 BC0s; disabled link 3 also bad but ignored.
    for (int i = 0; i < 7; i++) begin
      orbit(7'h28);
      if (i == 0) begin
        tick(1);
        check("link_good[5] after first bad BC0", lnk.link_good[5], 0);
        check("link_good[4] unaffected", lnk.link_good[4], 1);
      end
    end
    check("7 bad BC0 no recovery", lnk.busy, 0);
    check("crc_err_cnt[5] after 7", lnk.crc_err_cnt[5], 7);
    check("disabled link crc_err_cnt[3]", lnk.crc_err_cnt[3], 0);
    sb_soft.push_back(16);
    sb_buf.push_back(4);
    orbit(7'h28);
    check("8th bad BC0 recovery", lnk.busy, 1);
    check("crc_err_cnt[5] after 8", lnk.crc_err_cnt[5], 8);
    check("error recovery_cnt", lnk.recovery_cnt, 3);
    wait_buf_done("error recovery");
    settle("error recovery", 7'h00);
    tick(2);
    check("post-recovery link_good", lnk.link_good, 7'h77);

    // Link 2: 7 bad, 1 good, 7 bad must not trip.
    for (int i = 0; i < 7; i++) orbit(7'h04);
    orbit(7'h00);
    tick(1);
    check("link_good[2] after good BC0", lnk.link_good[2], 1);
    for (int i = 0; i < 7; i++) orbit(7'h04);
    check("interrupted run busy", lnk.busy, 0);
    check("interrupted run recovery_cnt", lnk.recovery_cnt, 3);
    check("crc_err_cnt[2]", lnk.crc_err_cnt[2], 14);

    // force_reset in SETTLE, then again 5 cycles into RESET_RX.
    sb_soft.push_back(16);
    sb_buf.push_back(4);
    lnk.force_reset = 1'b1; tick(1); lnk.force_reset = 1'b0;
    wait_buf_done("force to settle");
    check("force from MONITOR recovery_cnt", lnk.recovery_cnt, 4);
    sb_soft.push_back(21);
    sb_buf.push_back(4);
    lnk.force_reset = 1'b1; tick(1); lnk.force_reset = 1'b0;
    tick(4);
    lnk.force_reset = 1'b1; tick(1); lnk.force_reset = 1'b0;
    check("double force recovery_cnt", lnk.recovery_cnt, 6);
    wait_buf_done("double force");
    settle("double force", 7'h00);
    tick(2);
    check("double force link_good", lnk.link_good, 7'h77);

    // Saturate crc_err_cnt[0], then clear together with an error.
    lnk.cnt_clear = 1'b1; tick(1); lnk.cnt_clear = 1'b0;
    check("cnt_clear recovery_cnt", lnk.recovery_cnt, 0);
    check("cnt_clear crc_err_cnt", 32'(lnk.crc_err_cnt === '0), 1);
    lnk.crc_match = 7'h7E;
    tick(65534);
    check("crc_err_cnt[0] near max", lnk.crc_err_cnt[0], 16'hFFFE);
    tick(1);
    check("crc_err_cnt[0] at max", lnk.crc_err_cnt[0], 16'hFFFF);
    tick(2);
    check("crc_err_cnt[0] no wrap", lnk.crc_err_cnt[0], 16'hFFFF);
    lnk.cnt_clear = 1'b1; tick(1); lnk.cnt_clear = 1'b0;
    check("clear wins over increment", lnk.crc_err_cnt[0], 0);
    tick(1);
    check("crc_err_cnt[0] counts after clear", lnk.crc_err_cnt[0], 1);
    lnk.crc_match = '1;
    check("no BC0 no recovery", lnk.busy, 0);

    tick(4);
    check("soft_reset_rx scoreboard drained", sb_soft.size(), 0);
    check("rxbufreset scoreboard drained", sb_buf.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
